pcihellocore_led_fader: RTL

Downstream consumer of the core's 32-bit LED PIO output word. It turns the static on/off bits written by the host into per-LED brightness ramps: each LED fades linearly up or down at a host-selected rate and is rendered by an 8-bit PWM. It sits between the PIO register output and the board LED pins, inside the same clock domain.

---
 rtl/pcihellocore_led_fader.sv | 84 ++++++++
 1 files changed

// File: rtl/pcihellocore_led_fader.sv
// LED fader: turns the static on/off bits of the PIO LED word into linear brightness ramps rendered by an 8-bit PWM.
// Optional gamma curve on the duty cycle when PCIHELLOCORE_LED_FADER_GAMMA_EN is defined.
module pcihellocore_led_fader #(
    parameter int NUM_LEDS = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         led_word,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int PRE_W = $clog2(PRESCALE);

    // led_word is a static level from the PIO register: it is simply
    // sampled every cycle, there is no valid/ready handshake on this path.
    logic [31:0]                word_q;
    logic [PRE_W-1:0]           pre;
    logic [3:0]                 div;
    logic [7:0]                 pwm_cnt;
    logic [NUM_LEDS-1:0][7:0]   level;
    logic [NUM_LEDS-1:0][7:0]   duty;
    logic [NUM_LEDS-1:0]        target;
    logic [NUM_LEDS-1:0]        off_endpoint;
    logic [3:0]                 rate;
    logic                       tick;
    logic                       step;
    logic                       unused_bits;

    assign target      = word_q[NUM_LEDS-1:0];
    assign rate        = word_q[31:28];
    assign unused_bits = ^word_q;

    assign tick = (pre == PRE_W'(PRESCALE - 1));
    // A lowered rate that is already at or below div fires on the very next tick.
    assign step = tick && (div >= rate);

    always_comb begin
        duty         = '0;
        off_endpoint = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef PCIHELLOCORE_LED_FADER_GAMMA_EN
            duty[i] = (level[i] == 8'hFF) ? 8'hFF
                    : 8'((16'(level[i]) * 16'(level[i])) >> 8);
`else
            duty[i] = level[i];
`endif
            off_endpoint[i] = (level[i] != (target[i] ? 8'hFF : 8'h00));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            pre     <= '0;
            div     <= '0;
            pwm_cnt <= '0;
            level   <= '0;
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            word_q  <= led_word;
            pre     <= tick ? '0 : pre + PRE_W'(1);
            pwm_cnt <= pwm_cnt + 8'd1;
            busy    <= |off_endpoint;
            if (tick) begin
                div <= step ? 4'd0 : div + 4'd1;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                // Saturating ramp toward the registered target; endpoints hold.
                if (step) begin
                    if (target[i] && level[i] != 8'hFF) begin
                        level[i] <= level[i] + 8'd1;
                    end else if (!target[i] && level[i] != 8'h00) begin
                        level[i] <= level[i] - 8'd1;
                    end
                end
                led_out[i] <= (duty[i] == 8'hFF) | (duty[i] > pwm_cnt);
            end
        end
    end

endmodule
